// File: rtl/sirv_gnrl_beat_split.sv
// ============================================================================
// Module   : sirv_gnrl_beat_split
// Purpose  : Valid/ready width downsizer. Takes one IW-bit word and emits it
//            as RATIO beats of OW bits each, least-significant beat first.
//            The output handshake follows the generic pipe-stage rules, so the
//            two blocks chain directly.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            i_vld/i_rdy/i_dat  - wide input word handshake
//            i_len              - beats-minus-one (only with the macro below)
//            o_vld/o_rdy/o_dat  - narrow output beat handshake
//            o_last             - current beat is the final beat of the word
// Options  : `define SIRV_GNRL_BEAT_SPLIT_LEN_EN adds the i_len port so a word
//            may emit fewer than RATIO beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sirv_gnrl_beat_split #(
  parameter int  IW        = 64,
  parameter int  RATIO     = 2,
  parameter int  OW        = IW / RATIO,
  parameter bit  CUT_READY = 1'b0,
  localparam int C_CNT_W   = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_vld,
  output logic               i_rdy,
  input  logic [IW-1:0]      i_dat,
`ifdef SIRV_GNRL_BEAT_SPLIT_LEN_EN
  input  logic [C_CNT_W-1:0] i_len,
`endif
  output logic               o_vld,
  input  logic               o_rdy,
  output logic [OW-1:0]      o_dat,
  output logic               o_last
);

  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(RATIO - 1);

  logic               r_busy;
  logic [IW-1:0]      r_hold;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_lidx;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_is_last;

  assign w_in_hs   = i_vld & i_rdy;
  assign w_out_hs  = o_vld & o_rdy;
  assign w_is_last = (r_cnt == w_lidx);

  assign o_vld  = r_busy;
  assign o_last = r_busy & w_is_last;

  // Beat select: a compare-and-pick loop keeps every index width exact.
  always_comb begin
    o_dat = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (r_cnt == C_CNT_W'(i)) begin
        o_dat = r_hold[i*OW +: OW];
      end
    end
  end

  generate
    if (CUT_READY) begin : g_cut_ready
      // Registered-only ready: costs one idle cycle between words.
      assign i_rdy = ~r_busy;
    end else begin : g_pass_ready
      // Allow a reload in the same cycle the last beat pops (no bubble).
      assign i_rdy = ~r_busy | (o_rdy & o_last);
    end
  endgenerate

`ifdef SIRV_GNRL_BEAT_SPLIT_LEN_EN
  logic [C_CNT_W-1:0] r_lidx;
  logic [C_CNT_W-1:0] w_len_clamp;

  // Lengths beyond the word clamp to the final beat.
  assign w_len_clamp = ({1'b0, i_len} > {1'b0, C_LAST}) ? C_LAST : i_len;
  assign w_lidx      = r_lidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lidx <= C_LAST;
    end else if (w_in_hs) begin
      r_lidx <= w_len_clamp;
    end
  end
`else
  assign w_lidx = C_LAST;
`endif

  // Reload takes priority over the last-beat pop so back-to-back words
  // stream without dropping o_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_hold <= '0;
      r_cnt  <= '0;
    end else if (w_in_hs) begin
      r_busy <= 1'b1;
      r_hold <= i_dat;
      r_cnt  <= '0;
    end else if (w_out_hs) begin
      if (w_is_last) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
